weight_loader: RTL and testbench

- Sequencer that walks weight memory and streams weight rows into the systolic array's weight inputs, skewed diagonally.
- Sits directly downstream of the weight memory. It drives the memory's 13-bit address and consumes its four registered 16-bit weight outputs.
- Presents column j of each row j cycles later than column 0, matching the systolic array's diagonal wavefront.
- Controlled by a start/busy/done handshake from the top-level controller.

---
 rtl/weight_loader_pkg.sv | 23 ++
 rtl/skew_delay.sv | 43 ++++
 rtl/weight_loader.sv | 135 +++++++++++++
 tb/tb_weight_loader.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/weight_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : weight_loader_pkg
// Description : Shared constants and state encoding for the weight loader.
// Revision    : 1.0 - initial release
// ============================================================================
package weight_loader_pkg;

  localparam int DATA_W     = 16;  // one weight word
  localparam int ADDR_W     = 13;  // weight memory address width
  localparam int CNT_W      = 4;   // row-count width (up to 15 rows)
  localparam int NUM_COLS   = 4;   // systolic array columns fed per row
  localparam int ROW_STRIDE = 4;   // address step between consecutive rows

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/skew_delay.sv
`default_nettype none
// ============================================================================
// Module      : skew_delay
// Description : Data+valid shift register of DEPTH stages. Data entering with
//               valid low is stored as zero, so the output never shows stale
//               words while its valid is low.
// Revision    : 1.0 - initial release
// ============================================================================
module skew_delay #(
  parameter int DEPTH  = 1,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic [DEPTH-1:0]  valid_q;
  logic [DATA_W-1:0] data_q [DEPTH];

  // Shift valid and zero-masked data one stage per clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      valid_q[0] <= valid_i;
      data_q[0]  <= valid_i ? data_i : '0;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign data_o  = data_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/weight_loader.sv
`default_nettype none
// ============================================================================
// Module      : weight_loader
// Description : Walks weight memory one 4-word row per cycle and streams the
//               rows into the systolic array, column j delayed j cycles more
//               than column 0 to match the diagonal wavefront.
// Revision    : 1.0 - initial release
// ============================================================================
module weight_loader
  import weight_loader_pkg::*;
#(
  parameter int DATA_W = weight_loader_pkg::DATA_W,
  parameter int ADDR_W = weight_loader_pkg::ADDR_W,
  parameter int CNT_W  = weight_loader_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_rows,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_w1,
  input  logic [DATA_W-1:0] mem_w2,
  input  logic [DATA_W-1:0] mem_w3,
  input  logic [DATA_W-1:0] mem_w4,
  output logic [DATA_W-1:0] w_out1,
  output logic [DATA_W-1:0] w_out2,
  output logic [DATA_W-1:0] w_out3,
  output logic [DATA_W-1:0] w_out4,
  output logic [3:0]        w_valid
);

  // Drain lasts until the last row's final column has been shown.
  localparam int DRAIN_W = $clog2(NUM_COLS + 1);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   left_q, left_d;    // rows still to issue after this one
  logic [DRAIN_W-1:0] drain_q, drain_d;  // drain cycles remaining
  logic               pend_q;            // memory output holds a requested row

  logic [DATA_W-1:0]  mem_col [NUM_COLS];
  logic [DATA_W-1:0]  out_col [NUM_COLS];

  // State, address and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      left_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      left_q  <= left_d;
      drain_q <= drain_d;
    end
  end

  // Next-state logic: issue rows, then drain the skew pipeline, then pulse done.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    left_d  = left_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_rows != '0) begin
            state_d = FETCH;
            addr_d  = base_addr;
            left_d  = num_rows - CNT_W'(1);
          end else begin
            // Zero-row load: one busy cycle, no memory access, then done.
            state_d = DRAIN;
            drain_d = '0;
          end
        end
      end
      FETCH: begin
        if (left_q == '0) begin
          state_d = DRAIN;
          drain_d = DRAIN_W'(NUM_COLS);
        end else begin
          addr_d = addr_q + ADDR_W'(ROW_STRIDE);
          left_d = left_q - CNT_W'(1);
        end
      end
      DRAIN: begin
        if (drain_q == '0) state_d = DONE;
        else               drain_d = drain_q - DRAIN_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Track the memory's one-cycle read latency for each issued address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pend_q <= 1'b0;
    else        pend_q <= (state_q == FETCH);
  end

  assign busy     = (state_q == FETCH) || (state_q == DRAIN);
  assign done     = (state_q == DONE);
  assign mem_addr = addr_q;

  assign mem_col[0] = mem_w1;
  assign mem_col[1] = mem_w2;
  assign mem_col[2] = mem_w3;
  assign mem_col[3] = mem_w4;

  for (genvar j = 0; j < NUM_COLS; j++) begin : g_col
    skew_delay #(
      .DEPTH  (j + 1),
      .DATA_W (DATA_W)
    ) u_skew (
      .clk     (clk),
      .reset   (reset),
      .valid_i (pend_q),
      .data_i  (mem_col[j]),
      .valid_o (w_valid[j]),
      .data_o  (out_col[j])
    );
  end

  assign w_out1 = out_col[0];
  assign w_out2 = out_col[1];
  assign w_out3 = out_col[2];
  assign w_out4 = out_col[3];

endmodule
`default_nettype wire

// File: tb/tb_weight_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_weight_loader
// Description : Scoreboard bench for weight_loader with a behavioural model of
//               load timing and a registered weight memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_weight_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [12:0] base_addr;
  logic [3:0]  num_rows;
  logic        busy, done;
  logic [12:0] mem_addr;
  logic [15:0] mem_w1, mem_w2, mem_w3, mem_w4;
  logic [15:0] w_out1, w_out2, w_out3, w_out4;
  logic [3:0]  w_valid;

  always #5 clk = ~clk;

  weight_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .num_rows  (num_rows),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_w1    (mem_w1),
    .mem_w2    (mem_w2),
    .mem_w3    (mem_w3),
    .mem_w4    (mem_w4),
    .w_out1    (w_out1),
    .w_out2    (w_out2),
    .w_out3    (w_out3),
    .w_out4    (w_out4),
    .w_valid   (w_valid)
  );

  // Memory word at address a is 16'h1000 + a; output j reads address + j.
  function automatic logic [15:0] memf(input logic [12:0] b, input int off);
    logic [12:0] a;
    a = b + 13'(off);
    return 16'h1000 + {3'b000, a};
  endfunction

  always @(posedge clk) begin
    mem_w1 <= memf(mem_addr, 0);
    mem_w2 <= memf(mem_addr, 1);
    mem_w3 <= memf(mem_addr, 2);
    mem_w4 <= memf(mem_addr, 3);
  end

  // Cycle k is the interval after the k-th rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  typedef struct { int cyc; logic [15:0] d; } exp_t;
  exp_t        colq [4][$];
  int          next_ok  = 1 << 30;   // earliest edge that may accept start
  int          bs = -10, be = -10, dc = -10;
  int          ld_s = 0, ld_n = 0;
  logic [12:0] ld_base = '0, prev_addr = '0;
  bit          acc;

  int checks   = 0;
  int failures = 0;

  function automatic logic [12:0] addr_at(input int c);
    int k;
    if (ld_n == 0 || c < ld_s) return prev_addr;
    k = c - ld_s;
    if (k > ld_n - 1) k = ld_n - 1;
    return ld_base + 13'(4 * k);
  endfunction

  task automatic accept(input int s, input logic [12:0] b, input int n);
    prev_addr = addr_at(s - 1);
    ld_s = s; ld_base = b; ld_n = n;
    bs = s;
    if (n == 0) begin
      be = s; dc = s + 1; next_ok = s + 3;
    end else begin
      be = s + n + 4; dc = s + n + 5; next_ok = s + n + 7;
      for (int j = 0; j < 4; j++)
        for (int r = 0; r < n; r++)
          colq[j].push_back('{cyc: s + r + 2 + j, d: memf(b, 4 * r + j)});
    end
  endtask

  task automatic drive(input logic st, input logic [12:0] b, input logic [3:0] n);
    @(negedge clk);
    start = st; base_addr = b; num_rows = n;
    acc = 1'b0;
    if (reset && st && (cyc + 1 >= next_ok)) begin
      accept(cyc + 1, b, int'(n));
      acc = 1'b1;
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    for (int j = 0; j < 4; j++) colq[j].delete();
    bs = -10; be = -10; dc = -10; ld_n = 0; prev_addr = '0;
    next_ok = 1 << 30;
    repeat (cycles) @(negedge clk);
    reset = 1'b1;
    next_ok = cyc + 1;
  endtask

  task automatic wait_idle();
    while (cyc + 1 < next_ok) drive(1'b0, base_addr, num_rows);
  endtask

  task automatic check(input string nm, input int c, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, c, got, want);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      int c;
      logic [15:0] wo [4];
      @(negedge clk);
      #1;
      c = cyc;
      wo[0] = w_out1; wo[1] = w_out2; wo[2] = w_out3; wo[3] = w_out4;
      check("busy", c, 32'(busy), 32'((c >= bs) && (c <= be)));
      check("done", c, 32'(done), 32'(c == dc));
      check("mem_addr", c, 32'(mem_addr), 32'(addr_at(c)));
      for (int j = 0; j < 4; j++) begin
        bit has;
        has = (colq[j].size() > 0) && (colq[j][0].cyc == c);
        check($sformatf("w_valid[%0d]", j), c, 32'(w_valid[j]), 32'(has));
        if (has) begin
          check($sformatf("w_out%0d", j + 1), c, 32'(wo[j]), 32'(colq[j][0].d));
          void'(colq[j].pop_front());
        end else begin
          check($sformatf("w_out%0d_zero", j + 1), c, 32'(wo[j]), 32'h0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; start = 1'b0; base_addr = '0; num_rows = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    next_ok = cyc + 1;
    drive(1'b0, 13'h0, 4'd0);

    // Basic load: base 8, two rows.
    drive(1'b1, 13'h0008, 4'd2);
    drive(1'b0, 13'h0, 4'd0);
    wait_idle();

    // Zero-row load.
    drive(1'b1, 13'h0123, 4'd0);
    drive(1'b0, 13'h0, 4'd0);
    wait_idle();

    // Address wrap.
    drive(1'b1, 13'h1FFC, 4'd2);
    drive(1'b0, 13'h0, 4'd0);
    wait_idle();

    // Starts while busy are ignored; a held start retriggers after done.
    drive(1'b1, 13'h0040, 4'd3);
    for (int i = 0; i < 5; i++) drive(i[0] ? 1'b0 : 1'b1, 13'h0777, 4'd9);
    for (int i = 0; i < 20 && !acc; i++) drive(1'b1, 13'h0200, 4'd1);
    check("retrigger_accepted", cyc, 32'(acc), 32'h1);
    drive(1'b0, 13'h0, 4'd0);
    wait_idle();

    // Reset during cycle 4 of a four-row load, then a clean load.
    drive(1'b1, 13'h0100, 4'd4);
    for (int i = 0; i < 4; i++) drive(1'b0, 13'h0, 4'd0);
    do_reset(2);
    drive(1'b1, 13'h0300, 4'd4);
    drive(1'b0, 13'h0, 4'd0);
    wait_idle();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 249) == 0) do_reset($urandom_range(1, 3));
      else drive($urandom_range(0, 2) == 0, 13'($urandom), 4'($urandom_range(0, 15)));
    end
    drive(1'b0, 13'h0, 4'd0);
    wait_idle();
    repeat (4) drive(1'b0, 13'h0, 4'd0);

    for (int j = 0; j < 4; j++)
      check($sformatf("col%0d_drained", j), cyc, 32'(colq[j].size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
